// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer: word-addressed memory bank with wait states and error response
// Optional byte strobes (pstrb) are enabled by defining APB_SLAVE_PSTRB_EN.
module apb_slave_mem #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [31:0]         paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int          IDX_W  = $clog2(DEPTH);
  localparam int          STRB_W = DATA_W / 8;
  localparam int          D      = int'(DEPTH);
  localparam logic [31:0] SPAN   = 32'(DEPTH * 4);
  localparam logic [2:0]  WAIT_N = 3'(WAIT_CYCLES);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                write_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   prdata_q;
  logic [DATA_W-1:0]   mem_q [D];

  logic [31:0]         offset;
  logic                legal;
  logic [IDX_W-1:0]    idx;
  logic [STRB_W-1:0]   strb_in;
  logic                setup;
  logic                complete;

  // Subtracting first lets the unsigned compare also reject paddr below BASE_ADDR.
  assign offset = paddr - BASE_ADDR;
  assign legal  = (offset < SPAN) && (paddr[1:0] == 2'b00);
  assign idx    = offset[IDX_W+1:2];

`ifdef APB_SLAVE_PSTRB_EN
  assign strb_in = pstrb;
`else
  assign strb_in = '1;
`endif

  assign setup    = psel && !penable;
  assign complete = (state_q == ST_ACCESS) && psel && penable && (cnt_q == 3'd0);

  assign prdata  = prdata_q;
  assign pready  = complete;
  assign pslverr = complete && err_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
      for (int i = 0; i < D; i++) begin
        mem_q[i] <= '0;
      end
    end else if (setup) begin
      // A setup phase restarts the transfer from either state.
      state_q <= ST_ACCESS;
      cnt_q   <= WAIT_N;
      idx_q   <= idx;
      write_q <= pwrite;
      err_q   <= !legal;
      wdata_q <= pwdata;
      strb_q  <= strb_in;
      if (!pwrite) begin
        prdata_q <= legal ? mem_q[idx] : '0;
      end
    end else if (state_q == ST_ACCESS) begin
      if (!psel) begin
        state_q <= ST_IDLE;
      end else if (cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end else begin
        state_q <= ST_IDLE;
        if (write_q && !err_q) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) begin
              mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule
